// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order fetches at the current PC, tags each returned word with
// its PC and queues it for decode, dropping responses made stale by a redirect.
module instr_fetch_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic                  pc_en,
   input  logic                  flush,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW:0] DepthSum = (CntW + 1)'(DEPTH);

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e state_q, state_d;

   logic [CntW-1:0] outst_q, outst_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] discard_q, discard_d;

   logic [PtrW-1:0] tag_wr_q, tag_rd_q;
   logic [PtrW-1:0] q_wr_q, q_rd_q;

   logic [ADDR_WIDTH-1:0] tag_mem_q  [DEPTH];
   logic [DATA_WIDTH-1:0] q_data_q   [DEPTH];
   logic [ADDR_WIDTH-1:0] q_pc_q     [DEPTH];

   logic [CntW:0] credit_used;
   logic          accept;
   logic          rsp;
   logic          drop;
   logic          push;
   logic          pop;

   // Credit counts in-flight (including to-be-discarded) plus buffered entries.
   assign credit_used = {1'b0, outst_q} + {1'b0, count_q};

   always_comb begin
      imem_req    = 1'b0;
      imem_addr   = '0;
      accept      = 1'b0;
      pc_en       = 1'b0;
      rsp         = 1'b0;
      drop        = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      instr_valid = 1'b0;
      instr       = q_data_q[q_rd_q];
      instr_pc    = q_pc_q[q_rd_q];
      if (rst) begin
         imem_req    = !flush && (credit_used < DepthSum);
         imem_addr   = pc;
         accept      = imem_req && imem_gnt;
         pc_en       = accept;
         // A response with nothing outstanding is a protocol violation and is ignored.
         rsp         = imem_rvalid && (outst_q != '0);
         drop        = rsp && (flush || (discard_q != '0));
         push        = rsp && !drop;
         instr_valid = (count_q != '0);
         pop         = instr_valid && instr_ready;
      end
   end

   always_comb begin
      outst_d   = outst_q + CntW'(accept) - CntW'(rsp);
      count_d   = count_q + CntW'(push) - CntW'(pop);
      discard_d = discard_q;
      if (flush) begin
         count_d   = '0;
         discard_d = outst_d;
      end else if (rsp && (discard_q != '0)) begin
         discard_d = discard_q - CntW'(1);
      end
      state_d = (discard_d != '0) ? StDrain : StRun;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StRun;
         outst_q   <= '0;
         count_q   <= '0;
         discard_q <= '0;
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         q_wr_q    <= '0;
         q_rd_q    <= '0;
      end else begin
         state_q   <= state_d;
         outst_q   <= outst_d;
         count_q   <= count_d;
         discard_q <= discard_d;
         if (accept) tag_wr_q <= tag_wr_q + PtrW'(1);
         if (rsp)    tag_rd_q <= tag_rd_q + PtrW'(1);
         if (flush) begin
            q_wr_q <= '0;
            q_rd_q <= '0;
         end else begin
            if (push) q_wr_q <= q_wr_q + PtrW'(1);
            if (pop)  q_rd_q <= q_rd_q + PtrW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_mem_q[i] <= '0;
            q_data_q[i]  <= '0;
            q_pc_q[i]    <= '0;
         end
      end else begin
         if (accept) tag_mem_q[tag_wr_q] <= pc;
         if (push) begin
            q_data_q[q_wr_q] <= imem_rdata;
            q_pc_q[q_wr_q]   <= tag_mem_q[tag_rd_q];
         end
      end
   end

   rvalid_has_request: assert property (@(posedge clk) disable iff (!rst)
      imem_rvalid |-> (outst_q != '0))
      else $error("imem_rvalid with no outstanding fetch");

   credit_bounded: assert property (@(posedge clk) disable iff (!rst)
      credit_used <= DepthSum);

   state_tracks_discard: assert property (@(posedge clk) disable iff (!rst)
      (state_q == StDrain) == (discard_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-level reference model plus directed scenarios.
module tb_instr_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_en;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int checks = 0;
   int errors = 0;

   logic [31:0] infl[$];   // accepted fetches awaiting a response, oldest first
   logic [31:0] mq[$];     // PCs that decode should see, head first
   int          stale_n = 0;

   logic [31:0] mem_q[$];  // bench memory: addresses to answer
   logic        hold_resp;
   logic        dut_acc = 1'b0;
   logic        dut_pc_en = 1'b0;
   logic [31:0] dut_addr = '0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_en      (pc_en),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_ready(instr_ready)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: credit = in-flight + queued; a flush empties the queue and condemns
   // everything still in flight.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         infl.delete();
         mq.delete();
         stale_n = 0;
      end else begin
         logic        m_req;
         logic [31:0] p;
         m_req = !flush && ((infl.size() + mq.size()) < DEPTH);
         if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
         if (imem_rvalid && infl.size() != 0) begin
            p = infl.pop_front();
            if (stale_n > 0) stale_n--;
            else if (!flush) mq.push_back(p);
         end
         if (flush) begin
            mq.delete();
            stale_n = infl.size();
         end
         if (m_req && imem_gnt) infl.push_back(pc);
      end
   end

   always @(negedge clk) begin
      logic e_req;
      if (!rst) begin
         chk("rst_imem_req", imem_req, 0);
         chk("rst_pc_en", pc_en, 0);
         chk("rst_imem_addr", imem_addr, 0);
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_instr", instr, 0);
         chk("rst_instr_pc", instr_pc, 0);
      end else begin
         e_req = !flush && ((infl.size() + mq.size()) < DEPTH);
         chk("imem_req", imem_req, e_req);
         chk("pc_en", pc_en, e_req && imem_gnt);
         chk("imem_addr", imem_addr, pc);
         chk("instr_valid", instr_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("instr_pc", instr_pc, mq[0]);
            chk("instr", instr, mem_word(mq[0]));
         end
      end
      dut_acc   = imem_req && imem_gnt;
      dut_pc_en = pc_en;
      dut_addr  = imem_addr;
   end

   // Advance one clock; emulate the PC register and a one-cycle-latency memory.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (dut_pc_en) pc = pc + 32'd4;
      if (dut_acc) mem_q.push_back(dut_addr);
      if (!hold_resp && mem_q.size() != 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mem_q.pop_front());
      end else begin
         imem_rvalid = 1'b0;
      end
   endtask

   task automatic redirect(input logic [31:0] target);
      logic drained;
      cycle();
      imem_gnt    = 1'b0;
      instr_ready = 1'b1;
      hold_resp   = 1'b0;
      drained     = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (infl.size() == 0 && mq.size() == 0) begin
            drained = 1'b1;
            break;
         end
         cycle();
      end
      chk("drain_done", drained, 1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      pc    = target;
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp_pc);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            got = 1'b1;
            break;
         end
         cycle();
      end
      chk({name, "_valid_seen"}, got, 1);
      chk({name, "_first_pc"}, instr_pc, exp_pc);
   endtask

   logic [31:0] t1_addr [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h10};
   logic        t1_valid[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] t1_pc   [6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};

   initial begin
      int  n_acc;
      logic found;
      rst = 1'b0; pc = '0; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
      imem_rdata = '0; instr_ready = 1'b1; hold_resp = 1'b0;

      // 1: reset then streaming
      cycle(); cycle(); cycle();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t1_addr", imem_addr, t1_addr[i]);
         chk("t1_valid", instr_valid, t1_valid[i]);
         if (t1_valid[i]) chk("t1_pc", instr_pc, t1_pc[i]);
         cycle();
      end

      // 2: backpressure
      redirect(32'h0);
      imem_gnt = 1'b1; instr_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (pc_en) n_acc++;
         cycle();
      end
      @(negedge clk);
      chk("t2_accepts", n_acc, 2);
      chk("t2_req_off", imem_req, 0);
      chk("t2_pc_en_off", pc_en, 0);
      chk("t2_valid", instr_valid, 1);
      chk("t2_head_pc", instr_pc, 32'h0);
      cycle();
      instr_ready = 1'b1;
      @(negedge clk);
      chk("t2_pop_cycle_req", imem_req, 0);
      cycle();
      instr_ready = 1'b0;
      @(negedge clk);
      chk("t2_new_req", imem_req, 1);
      chk("t2_new_addr", imem_addr, 32'h8);
      chk("t2_new_head", instr_pc, 32'h4);

      // 3: grant stall
      redirect(32'h10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_req", imem_req, 1);
         chk("t3_addr", imem_addr, 32'h10);
         chk("t3_pc_en", pc_en, 0);
         cycle();
      end
      imem_gnt = 1'b1;
      @(negedge clk);
      chk("t3_pulse", pc_en, 1);
      cycle();
      imem_gnt = 1'b0;
      @(negedge clk);
      chk("t3_after", pc_en, 0);
      chk("t3_next_addr", imem_addr, 32'h14);

      // 4: flush with two outstanding
      redirect(32'h20);
      imem_gnt = 1'b1; hold_resp = 1'b1;
      @(negedge clk);
      chk("t4_acc0", imem_addr, 32'h20);
      cycle();
      @(negedge clk);
      chk("t4_acc1", imem_addr, 32'h24);
      chk("t4_acc1_en", pc_en, 1);
      cycle();
      @(negedge clk);
      chk("t4_full", imem_req, 0);
      cycle();
      flush = 1'b1;
      @(negedge clk);
      chk("t4_flush_req", imem_req, 0);
      cycle();
      flush = 1'b0; pc = 32'h100; hold_resp = 1'b0;
      wait_valid("t4", 32'h100);

      // 5: flush together with rvalid and pop
      redirect(32'h200);
      imem_gnt = 1'b1; instr_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (imem_rvalid && mq.size() != 0) begin
            flush = 1'b1;
            found = 1'b1;
            break;
         end
      end
      chk("t5_found", found, 1);
      @(negedge clk);
      chk("t5_pop_valid", instr_valid, 1);
      chk("t5_flush_req", imem_req, 0);
      cycle();
      flush = 1'b0; pc = 32'h300;
      @(negedge clk);
      chk("t5_emptied", instr_valid, 0);
      cycle();
      wait_valid("t5", 32'h300);

      // 6: asynchronous reset mid-stream
      redirect(32'h40);
      imem_gnt = 1'b1; instr_ready = 1'b0;
      cycle(); cycle(); cycle(); cycle();
      @(negedge clk);
      chk("t6_pre_valid", instr_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_valid", instr_valid, 0);
      chk("t6_async_req", imem_req, 0);
      chk("t6_async_pc_en", pc_en, 0);
      chk("t6_async_instr_pc", instr_pc, 0);
      cycle(); cycle();
      mem_q.delete();
      imem_rvalid = 1'b0;
      rst = 1'b1; pc = 32'h80; instr_ready = 1'b1;
      @(negedge clk);
      chk("t6_release_req", imem_req, 1);
      chk("t6_release_valid", instr_valid, 0);
      chk("t6_release_addr", imem_addr, 32'h80);
      cycle();
      wait_valid("t6", 32'h80);
      for (int i = 0; i < 6; i++) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
